yt_system_nios_oci_trace_capture: RTL and testbench

Parametrised trace-capture buffer for the Nios OCI debug path. It snapshots the packed direct-control-transfer (DCT) buffer and its valid-slot count into a DEPTH-entry FIFO, masking unused slots and counting drops on overflow. An end-of-test sequencer appends a terminator entry and raises `done` once the host has drained the FIFO. It sits beside the OCI test-bench hook and is read by a simple valid/ready consumer (JTAG/trace readout or simulation monitor).

---
 rtl/yt_system_nios_oci_trace_capture.sv | 154 +++++++++++++++
 tb/tb_yt_system_nios_oci_trace_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/yt_system_nios_oci_trace_capture.sv
// yt_system_nios_oci_trace_capture
//   Captures packed DCT buffer snapshots into a DEPTH-entry FIFO. Slots at or
//   above the (clamped) valid count are zeroed. Loads that find the FIFO full
//   are counted in a saturating drop counter. At end of test a terminator
//   entry {count=0, data=0} is appended, and `done` rises once the FIFO has
//   been drained.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   dct_buffer/count  : packed slots and number of valid slots
//   dct_load          : single-cycle capture strobe
//   test_ending       : level, test winding down (capture continues)
//   test_has_ended    : level, test finished (capture frozen)
//   rd_valid/ready    : valid/ready handshake for the FIFO head
//   rd_data           : head entry {count, masked buffer}, 0 while empty
//   fill_level        : entries held, 0..DEPTH
//   overflow_count    : dropped loads, saturating at 16'hFFFF
//   ending, done      : registered state decodes
module yt_system_nios_oci_trace_capture #(
  parameter int FIELD_W = 2,
  parameter int SLOTS   = 15,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SLOTS*FIELD_W-1:0]   dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       dct_load,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [CNT_W+SLOTS*FIELD_W-1:0] rd_data,
  output logic [ADDR_W:0]            fill_level,
  output logic [15:0]                overflow_count,
  output logic                       ending,
  output logic                       done
);

  localparam int DATA_W  = SLOTS * FIELD_W;
  localparam int ENTRY_W = CNT_W + DATA_W;

  typedef enum logic [2:0] {
    S_RUN,
    S_ENDING,
    S_MARK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     fill_q, fill_d;
  logic [15:0]         overflow_q, overflow_d;
  logic                ending_q, ending_d;
  logic                done_q, done_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];

  logic [CNT_W-1:0]    eff_cnt;
  logic [DATA_W-1:0]   masked;
  logic                pop, space, want, wr_en;
  logic [ENTRY_W-1:0]  wr_data;

  assign rd_valid       = (fill_q != '0);
  assign rd_data        = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fill_level     = fill_q;
  assign overflow_count = overflow_q;
  assign ending         = ending_q;
  assign done           = done_q;

  // Clamp the count and zero every slot at or above it.
  always_comb begin
    eff_cnt = dct_count;
    if (32'(dct_count) > SLOTS) eff_cnt = CNT_W'(SLOTS);
    masked = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (i < 32'(eff_cnt)) masked[i*FIELD_W +: FIELD_W] = dct_buffer[i*FIELD_W +: FIELD_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_data    = {eff_cnt, masked};

    pop   = rd_valid & rd_ready;
    // A simultaneous pop frees the slot being written, so full is not a blocker then.
    space = (fill_q != (ADDR_W+1)'(DEPTH)) | pop;
    want  = dct_load & (dct_count != '0) & ((state_q == S_RUN) | (state_q == S_ENDING));

    if (want) begin
      if (space) wr_en = 1'b1;
      else if (overflow_q != 16'hFFFF) overflow_d = overflow_q + 16'd1;
    end

    unique case (state_q)
      S_RUN: begin
        if (test_has_ended)   state_d = S_MARK;
        else if (test_ending) state_d = S_ENDING;
      end
      S_ENDING: if (test_has_ended) state_d = S_MARK;
      S_MARK: begin
        if (space) begin
          wr_en   = 1'b1;
          wr_data = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (fill_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)      fill_d = fill_q + 1'b1;
    else if (!wr_en && pop) fill_d = fill_q - 1'b1;

    ending_d = (state_d == S_ENDING);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= '0;
      ending_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      ending_q   <= ending_d;
      done_q     <= done_d;
    end
  end

  // Storage is not reset; rd_data is gated by rd_valid instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_yt_system_nios_oci_trace_capture.sv
module tb_yt_system_nios_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        dct_load = 1'b0;
  logic        test_ending = 1'b0;
  logic        test_has_ended = 1'b0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [33:0] rd_data;
  logic [4:0]  fill_level;
  logic [15:0] overflow_count;
  logic        ending;
  logic        done;

  int checks = 0;
  int errors = 0;

  yt_system_nios_oci_trace_capture #(
    .FIELD_W(2), .SLOTS(15), .CNT_W(4), .DEPTH(16), .ADDR_W(4)
  ) dut (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_load(dct_load), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .fill_level(fill_level), .overflow_count(overflow_count),
    .ending(ending), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of entries plus a phase number
  // (0 run, 1 ending, 2 mark, 3 drain, 4 done).
  logic [33:0] mq[$];
  logic [15:0] movf;
  int          mph;

  function automatic logic [33:0] mk(input logic [3:0] c, input logic [29:0] b);
    int          e;
    logic [63:0] m;
    e = (c > 4'd15) ? 15 : int'(c);
    m = (64'd1 << (e * 2)) - 64'd1;
    return {4'(e), b & m[29:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
    chk("rd_data", 64'(rd_data), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk("fill_level", 64'(fill_level), 64'(mq.size()));
    chk("overflow_count", 64'(overflow_count), 64'(movf));
    chk("ending", 64'(ending), 64'(mph == 1));
    chk("done", 64'(done), 64'(mph == 4));
  endtask

  task automatic model_step(input logic ld, input logic [3:0] c, input logic [29:0] b,
                            input logic rdy, input logic te, input logic th);
    int sz;
    bit pop, space, want;
    sz    = mq.size();
    pop   = (sz != 0) && rdy;
    space = (sz < 16) || pop;
    want  = ld && (c != 0) && (mph <= 1);
    if (pop) void'(mq.pop_front());
    if (want) begin
      if (space) mq.push_back(mk(c, b));
      else if (movf != 16'hFFFF) movf++;
    end
    case (mph)
      0: if (th) mph = 2; else if (te) mph = 1;
      1: if (th) mph = 2;
      2: if (space) begin mq.push_back(34'd0); mph = 3; end
      3: if (sz == 0) mph = 4;
      default: ;
    endcase
  endtask

  task automatic cyc(input logic ld, input logic [3:0] c, input logic [29:0] b,
                     input logic rdy, input logic te, input logic th);
    dct_load = ld; dct_count = c; dct_buffer = b; rd_ready = rdy;
    test_ending = te; test_has_ended = th;
    model_step(ld, c, b, rdy, te, th);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dct_load = 1'b0; dct_count = '0; dct_buffer = '0; rd_ready = 1'b0;
    test_ending = 1'b0; test_has_ended = 1'b0;
    mq.delete(); movf = '0; mph = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    compare_all();
  endtask

  typedef struct {
    logic        ld;
    logic [3:0]  c;
    logic [29:0] b;
    logic        rdy;
    logic        vld;
    logic [33:0] dat;
    logic [4:0]  fill;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 4'd3,  30'h3FFFFFFF, 1'b0, 1'b1, 34'h0C000003F, 5'd1};
    tbl[1] = '{1'b0, 4'd0,  30'h0,        1'b1, 1'b0, 34'h0,         5'd0};
    tbl[2] = '{1'b1, 4'hF,  30'h2AAAAAAA, 1'b0, 1'b1, 34'h3EAAAAAAA, 5'd1};
    tbl[3] = '{1'b1, 4'd0,  30'h3FFFFFFF, 1'b0, 1'b1, 34'h3EAAAAAAA, 5'd1};
    tbl[4] = '{1'b1, 4'd1,  30'h3FFFFFFF, 1'b1, 1'b1, 34'h040000003, 5'd1};
    tbl[5] = '{1'b0, 4'd0,  30'h0,        1'b1, 1'b0, 34'h0,         5'd0};

    do_reset();
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_fill", 64'(fill_level), 64'd0);

    foreach (tbl[i]) begin
      cyc(tbl[i].ld, tbl[i].c, tbl[i].b, tbl[i].rdy, 1'b0, 1'b0);
      chk("tbl_valid", 64'(rd_valid), 64'(tbl[i].vld));
      chk("tbl_data", 64'(rd_data), 64'(tbl[i].dat));
      chk("tbl_fill", 64'(fill_level), 64'(tbl[i].fill));
      chk("tbl_ovf", 64'(overflow_count), 64'd0);
    end

    // Overflow: 20 loads into a 16-entry FIFO, then push-while-full with a pop.
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 4'($urandom_range(1, 15)), 30'($urandom()), 1'b0, 1'b0, 1'b0);
    chk("ovf_fill16", 64'(fill_level), 64'd16);
    chk("ovf_count4", 64'(overflow_count), 64'd4);
    cyc(1'b1, 4'd7, 30'($urandom()), 1'b1, 1'b0, 1'b0);
    chk("ovf_popfill", 64'(fill_level), 64'd16);
    chk("ovf_popcount", 64'(overflow_count), 64'd4);

    // Pointer wrap: fill, pop 10, push 10, then drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'($urandom_range(1, 15)), 30'($urandom()), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'($urandom_range(1, 15)), 30'($urandom()), 1'b0, 1'b0, 1'b0);
    chk("wrap_fill16", 64'(fill_level), 64'd16);
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);

    // End-of-test sequence with two entries queued.
    do_reset();
    cyc(1'b1, 4'd2, 30'($urandom()), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd3, 30'($urandom()), 1'b0, 1'b1, 1'b0);
    chk("seq_ending", 64'(ending), 64'd1);
    chk("seq_fill2", 64'(fill_level), 64'd2);
    cyc(1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b1);
    chk("seq_term_fill", 64'(fill_level), 64'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b1);
    chk("seq_done_early", 64'(done), 64'd0);
    cyc(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b1);
    chk("seq_done", 64'(done), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'd5, 30'($urandom()), 1'b0, 1'b0, 1'b0);
    chk("seq_ignored", 64'(fill_level), 64'd0);

    // Full when the test ends: MARK waits for space, then reset mid-DRAIN.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'($urandom_range(1, 15)), 30'($urandom()), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b1);
    chk("mark_done", 64'(done), 64'd0);
    chk("mark_fill", 64'(fill_level), 64'd16);
    cyc(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b1);
    chk("mark_term_fill", 64'(fill_level), 64'd16);
    cyc(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    #2;
    chk("arst_valid", 64'(rd_valid), 64'd0);
    chk("arst_data", 64'(rd_data), 64'd0);
    chk("arst_fill", 64'(fill_level), 64'd0);
    chk("arst_ovf", 64'(overflow_count), 64'd0);
    chk("arst_ending", 64'(ending), 64'd0);
    chk("arst_done", 64'(done), 64'd0);

    // Randomized run against the model, with late end-of-test events.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 30'($urandom()),
          $urandom_range(0, 2) == 0,
          (i > 200) && ($urandom_range(0, 19) == 0),
          (i > 250) && ($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < 24; i++) cyc(1'b0, 4'd0, 30'd0, 1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
